synaptic_integrator: RTL and testbench

SYNAPTIC_INTEGRATOR -- requirements
Module: synaptic_integrator

---
 rtl/synaptic_integrator.sv | 102 ++++++++++
 tb/tb_synaptic_integrator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_integrator.sv
// rtl/synaptic_integrator.sv - four-input synaptic current integrator with leak and saturation
// Optional spike counter output enabled by SYNAPTIC_INTEGRATOR_SPIKE_COUNT_EN.
module synaptic_integrator #(
  parameter int DECAY_SHIFT = 2,
  parameter int GAIN_SHIFT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  pre_spike,
  input  logic [15:0] weight,
  input  logic        tick,
  output logic [7:0]  current_out,
  output logic        current_valid,
  output logic        busy,
`ifdef SYNAPTIC_INTEGRATOR_SPIKE_COUNT_EN
  output logic [15:0] spike_count,
`endif
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, ACC, UPDATE} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  snap_spike;
  logic [15:0] snap_weight;
  logic [5:0]  partial;
  logic [1:0]  idx;
  logic [3:0]  nibble;
  logic [15:0] leaked;
  logic [15:0] summed;
  logic [7:0]  current_next;

  assign busy   = (state != IDLE);
  assign nibble = snap_weight[{idx, 2'b00} +: 4];

  // Leak term is a right shift of the current itself, so the subtraction cannot underflow.
  assign leaked       = {8'd0, current_out} - ({8'd0, current_out} >> DECAY_SHIFT);
  assign summed       = leaked + ({10'd0, partial} << GAIN_SHIFT);
  assign current_next = (summed > 16'd255) ? 8'hFF : summed[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = ACC;
      ACC:     if (idx == 2'd0) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_spike    <= 4'd0;
      snap_weight   <= 16'd0;
      partial       <= 6'd0;
      idx           <= 2'd3;
      current_out   <= 8'd0;
      current_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      current_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            snap_spike  <= pre_spike;
            snap_weight <= weight;
            partial     <= 6'd0;
            idx         <= 2'd3;
          end
        end
        ACC: begin
          if (snap_spike[idx]) partial <= partial + {2'b00, nibble};
          idx <= idx - 2'd1;
        end
        UPDATE: begin
          current_out   <= current_next;
          current_valid <= 1'b1;
        end
        default: ;
      endcase
      // A tick is only honoured in IDLE; anything else is dropped and flagged.
      if (tick && state != IDLE) overrun <= 1'b1;
    end
  end

`ifdef SYNAPTIC_INTEGRATOR_SPIKE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_count <= 16'd0;
    end else if (state == ACC && snap_spike[idx] && spike_count != 16'hFFFF) begin
      spike_count <= spike_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_synaptic_integrator.sv
// tb/tb_synaptic_integrator.sv - scoreboard bench for synaptic_integrator against a reference model
module tb_synaptic_integrator;

  localparam int DS = 2;
  localparam int GS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  pre_spike = 4'd0;
  logic [15:0] weight = 16'd0;
  logic        tick = 1'b0;
  logic [7:0]  current_out;
  logic        current_valid;
  logic        busy;
  logic        overrun;
`ifdef SYNAPTIC_INTEGRATOR_SPIKE_COUNT_EN
  logic [15:0] spike_count;
  int          model_spikes = 0;
`endif

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int model_cur = 0;

  always #5 clk = ~clk;

  synaptic_integrator #(.DECAY_SHIFT(DS), .GAIN_SHIFT(GS)) dut (
    .clk(clk),
    .rst(rst),
    .pre_spike(pre_spike),
    .weight(weight),
    .tick(tick),
    .current_out(current_out),
    .current_valid(current_valid),
    .busy(busy),
`ifdef SYNAPTIC_INTEGRATOR_SPIKE_COUNT_EN
    .spike_count(spike_count),
`endif
    .overrun(overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: pre1..pre4 are spike bits 3..0 and weight nibbles high..low.
  function automatic int model_step(input int cur, input logic [3:0] ps, input logic [15:0] w);
    int syn = 0;
    int nxt;
    for (int pre = 1; pre <= 4; pre++)
      if (ps[4 - pre]) syn += int'((w >> (4 * (4 - pre))) & 16'hF);
    nxt = cur - cur / (1 << DS) + syn * (1 << GS);
    return (nxt > 255) ? 255 : nxt;
  endfunction

  function automatic int count_bits(input logic [3:0] ps);
    return int'(ps[0]) + int'(ps[1]) + int'(ps[2]) + int'(ps[3]);
  endfunction

  always @(negedge clk) begin
    if (current_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%0d expected=no_pulse", current_out);
      end else begin
        check("current_out", int'(current_out), exp_q.pop_front());
      end
    end
  end

  task automatic accept(input logic [3:0] ps, input logic [15:0] w);
    pre_spike = ps;
    weight    = w;
    tick      = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    model_cur = model_step(model_cur, ps, w);
    exp_q.push_back(model_cur);
`ifdef SYNAPTIC_INTEGRATOR_SPIKE_COUNT_EN
    model_spikes += count_bits(ps);
`endif
    pre_spike = 4'($urandom);
    weight    = 16'($urandom);
  endtask

  task automatic finish_step(input string name);
    int lat = 0;
    int bcnt = 0;
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (current_valid) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_valid expected=valid_within_20", name);
    end else begin
      check({name, "_latency"}, lat, 6);
      check({name, "_busy_cycles"}, bcnt, 5);
    end
  endtask

  task automatic do_step(input string name, input logic [3:0] ps, input logic [15:0] w);
    accept(ps, w);
    finish_step(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_cur = 0;
`ifdef SYNAPTIC_INTEGRATOR_SPIKE_COUNT_EN
    model_spikes = 0;
`endif
    check("rst_current", int'(current_out), 0);
    check("rst_valid", int'(current_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tick = 1'b0;
    do_reset();
    @(negedge clk);

    do_step("single", 4'b1000, 16'hF000);
    check("single_value", int'(current_out), 60);
    do_step("leak1", 4'b0000, 16'hFFFF);
    do_step("leak2", 4'b0000, 16'h1234);
    do_step("leak3", 4'b0000, 16'h0000);
    check("leak_value", int'(current_out), 26);
    check("no_overrun_yet", int'(overrun), 0);

    do_reset();
    @(negedge clk);
    do_step("full1", 4'b1111, 16'hFFFF);
    check("full1_value", int'(current_out), 240);
    do_step("full2", 4'b1111, 16'hFFFF);
    check("sat_value", int'(current_out), 255);

    // Second tick lands at E2 while weight is changed at E1.
    @(negedge clk);
    accept(4'b1010, 16'hA5C3);
    @(posedge clk);
    #1;
    weight    = 16'hFFFF;
    pre_spike = 4'b1111;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    repeat (10) @(negedge clk);
    check("overrun_set", int'(overrun), 1);
    check("overrun_queue_drained", exp_q.size(), 0);
    do_step("after_overrun", 4'b0110, 16'h3C7E);
    check("overrun_sticky", int'(overrun), 1);

    do_reset();
    check("overrun_cleared", int'(overrun), 0);
    accept(4'b1111, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_cur = 0;
`ifdef SYNAPTIC_INTEGRATOR_SPIKE_COUNT_EN
    model_spikes = 0;
`endif
    check("abort_current", int'(current_out), 0);
    check("abort_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_step("post_abort", 4'b0101, 16'h1234);
    check("post_abort_value", int'(current_out), 24);

    for (int n = 0; n < 30; n++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
      do_step("rand", 4'($urandom), 16'($urandom));
    end

`ifdef SYNAPTIC_INTEGRATOR_SPIKE_COUNT_EN
    check("spike_count", int'(spike_count), model_spikes);
`endif
    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
